// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   N            : operand/result width
//   F3_*         : funct3 operation codes, F7_MULDIV : funct7 of M-extension ops
//   md_state_e   : FSM state encoding
//   md_prep_t    : bundle produced by the operand preparation logic
package muldiv_pkg;

  localparam int N     = 32;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  typedef struct packed {
    logic [N-1:0] a_mag;          // |rs1| (or rs1 when treated unsigned)
    logic [N-1:0] b_mag;          // |rs2| (or rs2 when treated unsigned)
    logic         neg_prod;       // negate the 2N-bit product at the end
    logic         neg_quo;        // negate the quotient at the end
    logic         neg_rem;        // negate the remainder at the end
    logic         special;        // divide-by-zero or signed overflow
    logic [N-1:0] special_result; // result to preload for a special case
  } md_prep_t;

  // Two's complement negation when n is set.
  function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation for muldiv_unit.
//   funct3  : operation select
//   rs1_val : multiplicand / dividend
//   rs2_val : multiplier / divisor
//   prep    : magnitudes, end-of-operation sign fix flags, special-case result
module muldiv_operand_prep
  import muldiv_pkg::*;
(
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1_val,
  input  logic [N-1:0] rs2_val,
  output md_prep_t     prep
);

  logic signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;

  always_comb begin
    // Only MULHU/DIVU/REMU treat rs1 as unsigned; MULHSU additionally keeps rs2 unsigned.
    signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    signed_b = signed_a && (funct3 != F3_MULHSU);
    a_neg    = signed_a & rs1_val[N-1];
    b_neg    = signed_b & rs2_val[N-1];

    div_zero = (rs2_val == '0);
    div_ovf  = signed_b && (rs1_val == {1'b1, {(N-1){1'b0}}}) && (rs2_val == '1);

    prep          = '0;
    prep.a_mag    = neg_if(rs1_val, a_neg);
    prep.b_mag    = neg_if(rs2_val, b_neg);
    prep.neg_prod = a_neg ^ b_neg;
    prep.neg_quo  = a_neg ^ b_neg;
    prep.neg_rem  = a_neg;
    prep.special  = funct3[2] & (div_zero | div_ovf);

    // funct3[1] separates REM/REMU from DIV/DIVU. On overflow rs1 is already 0x80000000.
    if (funct3[1]) begin
      prep.special_result = div_zero ? rs1_val : '0;
    end else begin
      prep.special_result = div_zero ? '1 : rs1_val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a new operation (accepted in IDLE/DONE when flush=0)
//   funct3     : operation select
//   rs1_val    : multiplicand / dividend
//   rs2_val    : multiplier / divisor
//   flush      : abort current operation, suppress done
//   busy       : iteration in progress (stall request)
//   done       : one-cycle pulse, result valid
//   result     : registered result, held until the next completion
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1_val,
  input  logic [N-1:0] rs2_val,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  md_prep_t prep;

  muldiv_operand_prep u_prep (
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .prep    (prep)
  );

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             neg_prod_q, neg_prod_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [N-1:0]     opb_q, opb_d;      // multiplicand (MUL) or divisor (DIV)
  logic [2*N-1:0]   acc_q, acc_d;      // product accumulator; low half doubles as dividend/quotient
  logic [N:0]       rem_q, rem_d;      // partial remainder
  logic [N-1:0]     result_q, result_d;
  logic             busy_q, done_q;

  logic             accept;
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_acc, product;
  logic [N:0]       rem_shift, rem_diff, div_rem;
  logic [N-1:0]     div_quo;

  always_comb begin
    accept = start & ~flush & ((state_q == MD_IDLE) | (state_q == MD_DONE));

    // Multiply step: conditional add into the high half (with carry), then shift right.
    mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_acc = {mul_sum, acc_q[N-1:1]};
    product = neg_prod_q ? (~mul_acc + 1'b1) : mul_acc;

    // Divide step: the dividend MSB shifts into the remainder while the
    // quotient bit shifts into the vacated LSB of the same register.
    rem_shift = {rem_q[N-1:0], acc_q[N-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    div_rem   = rem_diff[N] ? rem_shift : rem_diff;
    div_quo   = {acc_q[N-2:0], ~rem_diff[N]};

    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    neg_prod_d = neg_prod_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    result_d   = result_q;

    case (state_q)
      MD_MUL: begin
        acc_d = mul_acc;
        if (cnt_q == '0) begin
          state_d  = MD_DONE;
          result_d = (f3_q == F3_MUL) ? product[N-1:0] : product[2*N-1:N];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DIV: begin
        acc_d = {acc_q[2*N-1:N], div_quo};
        rem_d = div_rem;
        if (cnt_q == '0) begin
          state_d  = MD_DONE;
          result_d = f3_q[1] ? neg_if(div_rem[N-1:0], neg_rem_q)
                             : neg_if(div_quo, neg_quo_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    if (accept) begin
      f3_d       = funct3;
      neg_prod_d = prep.neg_prod;
      neg_quo_d  = prep.neg_quo;
      neg_rem_d  = prep.neg_rem;
      opb_d      = funct3[2] ? prep.b_mag : prep.a_mag;
      acc_d      = {{N{1'b0}}, (funct3[2] ? prep.a_mag : prep.b_mag)};
      rem_d      = '0;
      cnt_d      = CNT_INIT;
      if (prep.special) begin
        state_d  = MD_DONE;
        result_d = prep.special_result;
      end else begin
        state_d  = funct3[2] ? MD_DIV : MD_MUL;
      end
    end

    // Abort: back to IDLE, and a completion landing this cycle is discarded.
    if (flush) begin
      state_d  = MD_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      neg_prod_q <= neg_prod_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      busy_q     <= (state_d == MD_MUL) || (state_d == MD_DIV);
      done_q     <= (state_d == MD_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: a vector table plus hand-written
// sequences for flush, start/flush collision, mid-operation reset and
// back-to-back operation.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. Cycle 1 is sampled
  // 1 time unit after the accepting edge.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    @(negedge clk);
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat    = 0;
    busy_n = 0;
    res    = 32'hDEAD_BEEF;
    for (int c = 1; c <= 100; c++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          busy_n;
    int          done_n;
    int          gap;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32}; // MUL 7*-3
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32}; // MULH
    vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32}; // MULHU
    vecs[3]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33, 32}; // MULHSU
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 32}; // DIV -7/2
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32}; // REM -7%2
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33, 32}; // DIVU
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33, 32}; // REMU
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0};  // DIVU /0
    vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1,  0};  // REM /0
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0};  // DIV ovf
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0};  // REM ovf
    vecs[12] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32}; // MULHU max
    vecs[13] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32}; // MUL -1*-1
    vecs[14] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32}; // DIV 7/-2
    vecs[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32}; // REM 7%-2

    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    rs1_val = '0;
    rs2_val = '0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, busy_n);
      $display("vec %0d f3=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d busy=%0d",
               i, vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, busy_n);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].busy_n);
    end

    // Flush during cycle 10 of a MUL: no done, result keeps prior value.
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, busy_n);
    check("pre_flush_result", res, 32'hFFFF_FFEB);
    @(negedge clk);
    funct3  = 3'b000;
    rs1_val = 32'd3;
    rs2_val = 32'd5;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_n++;
      @(posedge clk);
      #1;
    end
    $display("flush mid-MUL: done_count=%0d result=0x%08h", done_n, result);
    check("flush_no_done", done_n, 0);
    check("flush_result_held", result, 32'hFFFF_FFEB);
    run_op(3'b000, 32'd3, 32'd5, res, lat, busy_n);
    $display("restart MUL 3*5: result=0x%08h lat=%0d", res, lat);
    check("restart_result", res, 32'd15);
    check("restart_latency", lat, 33);

    // Start and flush in the same cycle: start is ignored.
    @(negedge clk);
    funct3  = 3'b101;
    rs1_val = 32'd9;
    rs2_val = 32'd0;
    start   = 1'b1;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_n++;
      if (busy) busy_n++;
      @(posedge clk);
      #1;
    end
    $display("start+flush: done_count=%0d busy_count=%0d result=0x%08h", done_n, busy_n, result);
    check("startflush_no_done", done_n, 0);
    check("startflush_no_busy", busy_n, 0);
    check("startflush_result", result, 32'd15);

    // Asynchronous reset in cycle 15 of a DIV.
    @(negedge clk);
    funct3  = 3'b100;
    rs1_val = 32'hFFFF_FFF9;
    rs2_val = 32'd2;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-DIV: busy=%0d done=%0d result=0x%08h", busy, done, result);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done | busy) done_n++;
      @(posedge clk);
      #1;
    end
    check("rst_stays_idle", done_n, 0);

    // Back-to-back: new start presented during the DONE cycle.
    run_op(3'b101, 32'd100, 32'd7, res, lat, busy_n);
    check("b2b_first_result", res, 32'd14);
    funct3 = 3'b111;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
    gap = 0;
    res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        gap = c;
        res = result;
        break;
      end
      @(posedge clk);
      #1;
    end
    $display("back-to-back: second result=0x%08h done pulses %0d cycles apart", res, gap);
    check("b2b_second_result", res, 32'd2);
    check("b2b_gap", gap, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
